// File: rtl/bp_be_wb_arbiter.sv
// ---------------------------------------------------------------------------
// bp_be_wb_arbiter
//
// Purpose:
//   Merges integer writebacks onto the single register-file write port.
//   The fixed-latency pipe has absolute priority and no backpressure.
//   Long-latency results (divider, FP-to-int, miss return) are buffered in a
//   small in-order FIFO. They drain whenever the pipe is idle.
//   A starvation counter raises stall_o toward issue. Issue then holds the
//   pipe off, so queued long results are guaranteed to drain.
//
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   pipe_v_i/addr_i/data_i    pipe writeback (always accepted)
//   long_v_i/addr_i/data_i    long-latency result, valid/ready handshake
//   long_ready_o              FIFO not full
//   rd_w_v_o/addr_o/data_o    registered register-file write
//   stall_o                   request to issue to suppress pipe writebacks
// ---------------------------------------------------------------------------
module bp_be_wb_arbiter #(
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2,
  parameter int starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        pipe_v_i,
  input  logic [reg_addr_width_p-1:0] pipe_addr_i,
  input  logic [data_width_p-1:0]     pipe_data_i,

  input  logic                        long_v_i,
  input  logic [reg_addr_width_p-1:0] long_addr_i,
  input  logic [data_width_p-1:0]     long_data_i,
  output logic                        long_ready_o,

  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [data_width_p-1:0]     rd_data_o,

  output logic                        stall_o
);

  // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
  localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int scnt_w_lp = $clog2(starve_limit_p + 1);

  localparam logic [ptr_w_lp-1:0]  ptr_last_lp   = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp-1:0]  cnt_full_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [scnt_w_lp-1:0] starve_max_lp = scnt_w_lp'(starve_limit_p);

  // -------------------------------------------------------------------------
  // FIFO storage and state
  // -------------------------------------------------------------------------
  logic [reg_addr_width_p-1:0] mem_addr_q [fifo_els_p];
  logic [data_width_p-1:0]     mem_data_q [fifo_els_p];

  logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]  count_q,  count_d;
  logic [scnt_w_lp-1:0] starve_q, starve_d;

  logic                        rd_w_v_q,  rd_w_v_d;
  logic [reg_addr_width_p-1:0] rd_addr_q, rd_addr_d;
  logic [data_width_p-1:0]     rd_data_q, rd_data_d;

  logic fifo_full, fifo_empty;
  logic enq, deq;

  logic [reg_addr_width_p-1:0] head_addr;
  logic [data_width_p-1:0]     head_data;

  logic                        win_v;
  logic [reg_addr_width_p-1:0] win_addr;
  logic [data_width_p-1:0]     win_data;

  assign fifo_full  = (count_q == cnt_full_lp);
  assign fifo_empty = (count_q == '0);

  // Ready looks only at the current occupancy. A same-cycle dequeue does not
  // open a slot, so a full FIFO never enqueues.
  assign long_ready_o = ~fifo_full;
  assign enq          = long_v_i & ~fifo_full;

  // The pipe always wins. The head drains only when the pipe is idle.
  assign deq = ~pipe_v_i & ~fifo_empty;

  assign head_addr = mem_addr_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  assign win_v    = pipe_v_i | ~fifo_empty;
  assign win_addr = pipe_v_i ? pipe_addr_i : head_addr;
  assign win_data = pipe_v_i ? pipe_data_i : head_data;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq) begin
      wr_ptr_d = (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter. It counts lost arbitrations while something is
  // queued, saturates at the limit, and clears once the head drains or the
  // FIFO is empty. If issue ignores stall_o, the pipe keeps winning and the
  // counter simply holds at the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || deq) begin
      starve_d = '0;
    end else if (pipe_v_i && (starve_q != starve_max_lp)) begin
      starve_d = starve_q + scnt_w_lp'(1);
    end
  end

  // Writes to x0 are dropped here. An x0 FIFO head is still dequeued.
  always_comb begin
    rd_w_v_d  = win_v & (win_addr != '0);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (win_v) begin
      rd_addr_d = win_addr;
      rd_data_d = win_data;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rd_w_v_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rd_w_v_q  <= rd_w_v_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset. Pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_addr_q[wr_ptr_q] <= long_addr_i;
      mem_data_q[wr_ptr_q] <= long_data_i;
    end
  end

  assign rd_w_v_o  = rd_w_v_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign stall_o   = (starve_q == starve_max_lp);

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bp_be_wb_arbiter
//
// Directed bench for bp_be_wb_arbiter with default parameters
// (fifo_els_p=2, starve_limit_p=4). Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, so each sample shows what the
// preceding edge registered.
// ---------------------------------------------------------------------------
module tb_bp_be_wb_arbiter;

  logic        clk_i;
  logic        reset_n_i;
  logic        pipe_v_i;
  logic [4:0]  pipe_addr_i;
  logic [63:0] pipe_data_i;
  logic        long_v_i;
  logic [4:0]  long_addr_i;
  logic [63:0] long_data_i;
  logic        long_ready_o;
  logic        rd_w_v_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  bp_be_wb_arbiter #(
    .data_width_p    (64),
    .reg_addr_width_p(5),
    .fifo_els_p      (2),
    .starve_limit_p  (4)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .pipe_v_i    (pipe_v_i),
    .pipe_addr_i (pipe_addr_i),
    .pipe_data_i (pipe_data_i),
    .long_v_i    (long_v_i),
    .long_addr_i (long_addr_i),
    .long_data_i (long_data_i),
    .long_ready_o(long_ready_o),
    .rd_w_v_o    (rd_w_v_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .stall_o     (stall_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] addr,
                          input logic [63:0] data);
    check_val({tag, "_v"}, 64'(rd_w_v_o), 64'd1);
    check_val({tag, "_addr"}, 64'(rd_addr_o), 64'(addr));
    check_val({tag, "_data"}, rd_data_o, data);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_rd_w_v"}, 64'(rd_w_v_o), 64'd0);
    check_val({tag, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
    check_val({tag, "_rd_data"}, rd_data_o, 64'd0);
    check_val({tag, "_stall"}, 64'(stall_o), 64'd0);
    check_val({tag, "_ready"}, 64'(long_ready_o), 64'd1);
  endtask

  // Issue must never drive the pipe while stall_o is high.
  always @(posedge clk_i) begin
    if (reset_n_i && stall_o) check_val("no_pipe_during_stall", 64'(pipe_v_i), 64'd0);
  end

  initial begin
    reset_n_i   = 1'b0;
    pipe_v_i    = 1'b0;
    pipe_addr_i = '0;
    pipe_data_i = '0;
    long_v_i    = 1'b0;
    long_addr_i = '0;
    long_data_i = '0;

    // Reset
    cyc(); cyc();
    check_reset_outs("reset");
    reset_n_i = 1'b1;

    // Pipe write: addr 5, data 0xAA, one-cycle latency
    pipe_v_i = 1'b1; pipe_addr_i = 5'd5; pipe_data_i = 64'hAA;
    cyc();
    check_wr("pipe", 5'd5, 64'hAA);
    pipe_v_i = 1'b0;
    cyc();
    check_val("pipe_idle_v", 64'(rd_w_v_o), 64'd0);

    // Single long write: accepted at edge E, written at edge E+2
    long_v_i = 1'b1; long_addr_i = 5'd7; long_data_i = 64'h1234;
    check_val("long_ready_empty", 64'(long_ready_o), 64'd1);
    cyc();
    long_v_i = 1'b0;
    check_val("long_no_bypass_v", 64'(rd_w_v_o), 64'd0);
    cyc();
    check_wr("long", 5'd7, 64'h1234);
    cyc();
    check_val("long_after_v", 64'(rd_w_v_o), 64'd0);

    // Fill: pipe held high, three long results back to back
    pipe_v_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 64'h11;
    long_v_i = 1'b1; long_addr_i = 5'd10; long_data_i = 64'hA0;
    cyc();                                         // accept #1 (count 1)
    check_val("fill_ready_1", 64'(long_ready_o), 64'd1);
    check_wr("fill_pipe_a", 5'd1, 64'h11);
    long_addr_i = 5'd11; long_data_i = 64'hA1;
    cyc();                                         // accept #2 (count 2)
    check_val("fill_ready_full", 64'(long_ready_o), 64'd0);
    long_addr_i = 5'd12; long_data_i = 64'hA2;
    cyc();                                         // full: #3 held
    check_val("fill_ready_still_full", 64'(long_ready_o), 64'd0);
    check_wr("fill_pipe_b", 5'd1, 64'h11);
    check_val("fill_stall_low", 64'(stall_o), 64'd0);
    pipe_v_i = 1'b0;
    cyc();                                         // deq #1; #3 not taken
    check_wr("fill_first", 5'd10, 64'hA0);
    check_val("fill_ready_reopen", 64'(long_ready_o), 64'd1);
    cyc();                                         // enq #3 and deq #2
    long_v_i = 1'b0;
    check_wr("fill_second", 5'd11, 64'hA1);
    check_val("fill_ready_count1", 64'(long_ready_o), 64'd1);
    cyc();                                         // deq #3
    check_wr("fill_third", 5'd12, 64'hA2);
    cyc();
    check_val("fill_drained_v", 64'(rd_w_v_o), 64'd0);

    // Starvation: one queued entry, the pipe wins four times
    pipe_v_i = 1'b1; pipe_addr_i = 5'd2; pipe_data_i = 64'h22;
    long_v_i = 1'b1; long_addr_i = 5'd20; long_data_i = 64'h5;
    cyc();                                         // enq, counter 0
    long_v_i = 1'b0;
    cyc(); cyc(); cyc();                           // counter 3
    check_val("starve_before_limit", 64'(stall_o), 64'd0);
    cyc();                                         // counter 4
    check_val("starve_stall", 64'(stall_o), 64'd1);
    check_wr("starve_pipe", 5'd2, 64'h22);
    pipe_v_i = 1'b0;
    cyc();                                         // head dequeued
    check_wr("starve_drain", 5'd20, 64'h5);
    check_val("starve_release", 64'(stall_o), 64'd0);
    cyc();

    // x0 filter: pipe write to x0, then long write to x0
    pipe_v_i = 1'b1; pipe_addr_i = 5'd0; pipe_data_i = 64'h77;
    cyc();
    check_val("x0_pipe_v", 64'(rd_w_v_o), 64'd0);
    pipe_v_i = 1'b0;
    long_v_i = 1'b1; long_addr_i = 5'd0; long_data_i = 64'h88;
    cyc();                                         // enq x0
    long_v_i = 1'b0;
    check_val("x0_long_enq_v", 64'(rd_w_v_o), 64'd0);
    cyc();                                         // deq x0, dropped
    check_val("x0_long_v", 64'(rd_w_v_o), 64'd0);

    // Two accepts with the pipe busy. Ready stays high after the first, so
    // the dropped x0 entry really left the FIFO.
    pipe_v_i = 1'b1; pipe_addr_i = 5'd3; pipe_data_i = 64'h33;
    long_v_i = 1'b1; long_addr_i = 5'd13; long_data_i = 64'hD1;
    cyc();
    check_val("x0_count_zero", 64'(long_ready_o), 64'd1);
    long_addr_i = 5'd14; long_data_i = 64'hD2;
    cyc();
    check_val("rst_pre_full", 64'(long_ready_o), 64'd0);

    // Asynchronous reset mid-cycle with two entries queued
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outs("async_rst");
    pipe_v_i = 1'b0;
    long_v_i = 1'b0;
    cyc();
    reset_n_i = 1'b1;
    cyc();
    check_val("post_rst_v0", 64'(rd_w_v_o), 64'd0);
    cyc();
    check_val("post_rst_v1", 64'(rd_w_v_o), 64'd0);
    cyc();
    check_val("post_rst_v2", 64'(rd_w_v_o), 64'd0);
    check_val("post_rst_ready", 64'(long_ready_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
